axi4_lite_master: RTL and testbench

- Single-outstanding AXI4-Lite master bridge. Converts a simple valid/ready command interface into AXI4-Lite AW/W/B/AR/R channel traffic, and returns one response per command.
- Sits directly upstream of the AXI4-Lite slave memory (32-bit address/data, 256-word space, SLVERR at or above 0x400).
- Used by test sequencers and CPU-side glue to access slave registers and memory.

---
 rtl/axi4_lite_pkg.sv | 22 ++
 rtl/axi4_lite_master.sv | 162 ++++++++++++++++
 tb/tb_axi4_lite_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: bus width defaults, response codes and the
// master bridge state encoding.
package axi4_lite_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } master_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready command into
// AW/W/B or AR/R traffic and hands back exactly one response.
//
// state   | meaning
// IDLE    | ready for a command (cmd_ready = 1)
// WR_REQ  | AW and W offered; each drops after its own handshake
// WR_RESP | BREADY high, waiting for the write response
// RD_ADDR | ARVALID high, waiting for ARREADY
// RD_DATA | RREADY high, waiting for read data
// RSP     | rsp_valid high until the consumer takes it
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int         ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [2:0] PROT_VAL   = 3'b000
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,

  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [2:0]                AWPROT,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      BVALID,
  output logic                      BREADY,
  input  logic [1:0]                BRESP,

  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [2:0]                ARPROT,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP
);

  master_state_t state;
  logic          aw_done;
  logic          w_done;
  logic          aw_fin;
  logic          w_fin;

  assign AWPROT    = PROT_VAL;
  assign ARPROT    = PROT_VAL;
  assign cmd_ready = (state == IDLE);

  // A channel counts as finished if it completed earlier or is completing now.
  assign aw_fin = aw_done | (AWVALID & AWREADY);
  assign w_fin  = w_done  | (WVALID  & WREADY);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      WVALID    <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            rsp_write <= cmd_write;
            if (cmd_write) begin
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              WSTRB   <= cmd_wstrb;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end

        WR_REQ: begin
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            BREADY  <= 1'b1;
            state   <= WR_RESP;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end

        WR_RESP: begin
          if (BVALID && BREADY) begin
            rsp_resp  <= BRESP;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            BREADY    <= 1'b0;
            state     <= RSP;
          end
        end

        RD_ADDR: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (RVALID && RREADY) begin
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            rsp_valid <= 1'b1;
            RREADY    <= 1'b0;
            state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master against a behavioural AXI4-Lite slave memory
// (256 words, SLVERR at or above 0x400) with adjustable AW/W ready delays.
module tb_axi4_lite_master;

  logic        ACLK;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] ARADDR, RDATA;

  axi4_lite_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- slave memory model ----------------
  logic [31:0] mem [256];
  int          aw_delay = 0, w_delay = 0;
  int          aw_wait, w_wait;
  int          aw_beats = 0, w_beats = 0;
  logic        aw_got, w_got;
  logic [31:0] awaddr_q, wdata_q, sa, sd;
  logic [3:0]  wstrb_q, ss;
  logic [7:0]  idx;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

  assign AWREADY = ARESETn && !aw_got && !BVALID && (aw_wait >= aw_delay);
  assign WREADY  = ARESETn && !w_got  && !BVALID && (w_wait  >= w_delay);
  assign ARREADY = ARESETn && !RVALID;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_got <= 1'b0; w_got <= 1'b0; BVALID <= 1'b0; RVALID <= 1'b0;
      aw_wait <= 0; w_wait <= 0; BRESP <= 2'b00; RRESP <= 2'b00; RDATA <= 32'h0;
    end else begin
      aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
      if (AWVALID && AWREADY) begin aw_got <= 1'b1; awaddr_q <= AWADDR; aw_beats++; end
      if (WVALID && WREADY) begin w_got <= 1'b1; wdata_q <= WDATA; wstrb_q <= WSTRB; w_beats++; end
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY))) begin
        sa = aw_got ? awaddr_q : AWADDR;
        sd = w_got ? wdata_q : WDATA;
        ss = w_got ? wstrb_q : WSTRB;
        if (sa < 32'h400) begin
          idx = sa[9:2];
          for (int b = 0; b < 4; b++) if (ss[b]) mem[idx][8*b +: 8] = sd[8*b +: 8];
          BRESP <= 2'b00;
        end else BRESP <= 2'b10;
        BVALID <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        if (ARADDR < 32'h400) begin RDATA <= mem[ARADDR[9:2]]; RRESP <= 2'b00; end
        else begin RDATA <= 32'h0; RRESP <= 2'b10; end
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  // VALID must stay asserted with stable payload until its handshake.
  int          viol = 0;
  logic        pend_aw = 1'b0, pend_w = 1'b0;
  logic [31:0] prev_awaddr, prev_wdata;
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      pend_aw = 1'b0; pend_w = 1'b0;
    end else begin
      if (pend_aw && !(AWVALID && AWADDR == prev_awaddr)) viol++;
      if (pend_w && !(WVALID && WDATA == prev_wdata)) viol++;
      pend_aw = AWVALID && !AWREADY; prev_awaddr = AWADDR;
      pend_w  = WVALID && !WREADY;   prev_wdata  = WDATA;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge ACLK) begin
    if (ARESETn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got response rdata %h resp %0d with empty queue", rsp_rdata, rsp_resp);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_write", {31'h0, rsp_write}, {31'h0, mon_e.wr});
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_resp", {30'h0, rsp_resp}, {30'h0, mon_e.resp});
      end
    end
  end

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] erd, input logic [1:0] eresp,
                        input bit push);
    int cnt;
    exp_t e;
    e.wr = wr; e.rdata = erd; e.resp = eresp;
    if (push) exp_q.push_back(e);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    cnt = 0;
    while (!cmd_ready && cnt < 200) begin @(negedge ACLK); cnt++; end
    if (cnt >= 200) fail_now("cmd_accept");
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin @(negedge ACLK); cnt++; end
    if (cnt >= 200) fail_now("rsp_drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int a0, w0, lat;

  initial begin
    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("rst_axi_valid_ready", {27'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_awaddr", AWADDR, 32'h0);
    chk("rst_wdata", WDATA, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // basic write/read with latency measurement
    do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 1'b1);
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge ACLK); lat++; end
    chk("write_latency", lat, 32'd3);
    drain();
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge ACLK); lat++; end
    chk("read_latency", lat, 32'd3);
    drain();

    // byte strobes
    do_cmd(1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00, 1'b1);
    do_cmd(1'b1, 32'h14, 32'h12345678, 4'b0101, 32'h0, 2'b00, 1'b1);
    do_cmd(1'b0, 32'h14, 32'h0, 4'h0, 32'hFF34FF78, 2'b00, 1'b1);
    drain();

    // SLVERR boundary
    do_cmd(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00, 1'b1);
    do_cmd(1'b1, 32'h400, 32'h11111111, 4'hF, 32'h0, 2'b10, 1'b1);
    do_cmd(1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1);
    do_cmd(1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00, 1'b1);
    drain();

    // independent AW/W handshakes
    a0 = aw_beats; w0 = w_beats; aw_delay = 3; w_delay = 0;
    do_cmd(1'b1, 32'h18, 32'h0BADF00D, 4'hF, 32'h0, 2'b00, 1'b1);
    drain();
    chk("aw_late_aw_beats", aw_beats - a0, 32'd1);
    chk("aw_late_w_beats", w_beats - w0, 32'd1);
    a0 = aw_beats; w0 = w_beats; aw_delay = 0; w_delay = 3;
    do_cmd(1'b1, 32'h1C, 32'h5A5AA5A5, 4'hF, 32'h0, 2'b00, 1'b1);
    drain();
    chk("w_late_aw_beats", aw_beats - a0, 32'd1);
    chk("w_late_w_beats", w_beats - w0, 32'd1);
    w_delay = 0;
    chk("valid_held_until_handshake", viol, 32'd0);
    do_cmd(1'b0, 32'h18, 32'h0, 4'h0, 32'h0BADF00D, 2'b00, 1'b1);
    do_cmd(1'b0, 32'h1C, 32'h0, 4'h0, 32'h5A5AA5A5, 2'b00, 1'b1);
    drain();

    // response back-pressure
    @(posedge ACLK); #1 rsp_ready = 1'b0;
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge ACLK); lat++; end
    if (lat >= 50) fail_now("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("bp_axi_idle", {27'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'h0);
      @(negedge ACLK);
    end
    @(posedge ACLK); #1 rsp_ready = 1'b1;
    drain();
    do_cmd(1'b0, 32'h14, 32'h0, 4'h0, 32'hFF34FF78, 2'b00, 1'b1);
    drain();

    // asynchronous reset mid-write
    aw_delay = 8;
    do_cmd(1'b1, 32'h20, 32'h77777777, 4'hF, 32'h0, 2'b00, 1'b0);
    chk("pre_reset_awvalid", {31'h0, AWVALID}, 32'h1);
    #2 ARESETn = 1'b0;
    #1;
    chk("async_rst_axi", {27'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'h0);
    chk("async_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    aw_delay = 0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    chk("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    drain();
    chk("final_valid_stability", viol, 32'd0);

    repeat (3) @(negedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
